// File: rtl/drv_share_arb_if.sv
// rtl/drv_share_arb_if.sv - request, data and driver-control bundle for drv_share_arb
interface drv_share_arb_if #(
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  d;
  logic [N-1:0]  gnt;
  logic [SW-1:0] sel;
  logic          drv_en;
  logic          drv_a;
  logic          timeout;

  // requesting logic side
  modport master (
    output req, d,
    input  gnt, sel, drv_en, drv_a, timeout
  );

  // arbiter side
  modport slave (
    input  req, d,
    output gnt, sel, drv_en, drv_a, timeout
  );
endinterface

// File: rtl/drv_share_arb.sv
// rtl/drv_share_arb.sv - round-robin owner sequencer for one shared inv4x driver
module drv_share_arb #(
  parameter int N       = 4,
  parameter int DEAD    = 2,
  parameter int MAXHOLD = 16
) (
  input logic           clk,
  input logic           rst,
  drv_share_arb_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int DW = $clog2(DEAD + 1);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
  localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DEAD
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt, gnt_nxt;
  logic [SW-1:0] sel, sel_nxt;
  logic          drv_en, drv_en_nxt;
  logic          timeout, timeout_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;

  logic [SW-1:0] win;
  logic          win_vld;
  int            idx;

  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!win_vld && bus.req[idx]) begin
        win     = SW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // next state and next registered outputs; timeout is a single-cycle pulse
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    drv_en_nxt  = drv_en;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    dead_nxt    = dead_cnt;
    unique case (state)
      S_IDLE: begin
        if (win_vld) begin
          state_nxt    = S_GRANT;
          gnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          sel_nxt      = win;
          drv_en_nxt   = 1'b1;
          hold_nxt     = HW'(1);
        end
      end
      S_GRANT: begin
        if (!bus.req[sel] || hold_cnt == HOLD_MAX) begin
          state_nxt   = S_DEAD;
          gnt_nxt     = '0;
          drv_en_nxt  = 1'b0;
          ptr_nxt     = (sel == LAST_IDX) ? '0 : sel + 1'b1;
          dead_nxt    = DW'(1);
          // req still high here means the hold limit forced the release
          timeout_nxt = bus.req[sel];
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      S_DEAD: begin
        if (dead_cnt == DEAD_MAX) state_nxt = S_IDLE;
        else                      dead_nxt  = dead_cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state and output registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      sel      <= '0;
      drv_en   <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      drv_en   <= drv_en_nxt;
      timeout  <= timeout_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      dead_cnt <= dead_nxt;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.sel     = sel;
  assign bus.drv_en  = drv_en;
  assign bus.timeout = timeout;
  // owner's data goes straight to the inverter input, masked when no one owns it
  assign bus.drv_a   = drv_en & bus.d[sel];
endmodule

// File: tb/tb_drv_share_arb.sv
// tb/tb_drv_share_arb.sv - self-checking bench for drv_share_arb
module tb_drv_share_arb;
  localparam int N       = 4;
  localparam int DEAD    = 2;
  localparam int MAXHOLD = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  drv_share_arb_if #(.N(N)) bus ();

  drv_share_arb #(.N(N), .DEAD(DEAD), .MAXHOLD(MAXHOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference: current owner (-1 none), cycles owned, cycles since release
  int m_owner, m_last, m_held, m_off, m_ptr;
  bit m_to;

  // observer of the driver-enable waveform
  logic [N-1:0] q_order[$];
  int           q_on[$];
  int           q_off[$];
  int           obs_run, obs_to;
  bit           obs_en, obs_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_held  = 0;
    m_off   = DEAD + 1;
    m_ptr   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_held == MAXHOLD) begin
        m_to    = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_off   = 1;
      end else begin
        m_held++;
      end
    end else if (m_off <= DEAD) begin
      m_off++;
    end else if (r != '0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  task automatic obs_reset();
    q_order.delete();
    q_on.delete();
    q_off.delete();
    obs_run  = 0;
    obs_to   = 0;
    obs_en   = 1'b0;
    obs_seen = 1'b0;
  endtask

  task automatic observe();
    if (bus.drv_en && !obs_en) begin
      q_order.push_back(bus.gnt);
      if (obs_seen) q_off.push_back(obs_run);
      obs_run  = 0;
      obs_seen = 1'b1;
    end else if (!bus.drv_en && obs_en) begin
      q_on.push_back(obs_run);
      obs_run = 0;
    end
    obs_run++;
    if (bus.timeout) obs_to++;
    obs_en = bus.drv_en;
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, " gnt"},     32'(bus.gnt),          32'(eg));
    chk({tag, " sel"},     32'(bus.sel),          32'(m_last));
    chk({tag, " drv_en"},  32'(bus.drv_en),       32'(m_owner >= 0));
    chk({tag, " timeout"}, 32'(bus.timeout),      32'(m_to));
    chk({tag, " drv_a"},   32'(bus.drv_a),        32'((m_owner >= 0) && bus.d[m_last]));
    chk({tag, " onehot"},  32'($onehot0(bus.gnt)), 32'(1));
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] dv, input string tag);
    bus.req = r;
    bus.d   = dv;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_outputs(tag);
    observe();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    bus.d   = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_reset();
    check_outputs("reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] dpat[4];
    logic         apat[4];
    logic [N-1:0] r;
    int           len;

    rst     = 1'b1;
    bus.req = '0;
    bus.d   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_reset();
    check_outputs("reset");

    // asynchronous reset while requester 2 owns the driver
    repeat (3) cycle(4'b0100, 4'b0100, "pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("async_rst gnt",    32'(bus.gnt),    32'(0));
    chk("async_rst drv_en", 32'(bus.drv_en), 32'(0));
    chk("async_rst drv_a",  32'(bus.drv_a),  32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_reset();
    cycle(4'b0100, 4'b0100, "post_rst");
    chk("post_rst gnt", 32'(bus.gnt), 32'(4'b0100));

    // all requesting: rotation with forced releases
    do_reset();
    for (int i = 0; i < 80; i++) cycle(4'b1111, 4'($urandom_range(0, 15)), "rr");
    chk("rr grants", 32'(q_order.size()), 32'(5));
    if (q_order.size() == 5) begin
      chk("rr order0", 32'(q_order[0]), 32'(4'b0001));
      chk("rr order1", 32'(q_order[1]), 32'(4'b0010));
      chk("rr order2", 32'(q_order[2]), 32'(4'b0100));
      chk("rr order3", 32'(q_order[3]), 32'(4'b1000));
      chk("rr order4", 32'(q_order[4]), 32'(4'b0001));
    end
    chk("rr on_runs", 32'(q_on.size()), 32'(4));
    foreach (q_on[i]) chk("rr on_len", 32'(q_on[i]), 32'(MAXHOLD));
    foreach (q_off[i]) chk("rr gap_len", 32'(q_off[i]), 32'(DEAD + 1));
    chk("rr timeouts", 32'(obs_to), 32'(4));

    // voluntary release after 5 cycles, then re-request
    do_reset();
    repeat (5) cycle(4'b0010, 4'b0000, "vol");
    cycle(4'b0000, 4'b0000, "vol");
    repeat (4) cycle(4'b0010, 4'b0000, "vol");
    chk("vol on_len",   (q_on.size()  > 0) ? 32'(q_on[0])  : 32'hffff, 32'(5));
    chk("vol gap_len",  (q_off.size() > 0) ? 32'(q_off[0]) : 32'hffff, 32'(DEAD + 1));
    chk("vol timeouts", 32'(obs_to), 32'(0));

    // requester 3 arrives during requester 0's grant and wins next
    do_reset();
    repeat (3)  cycle(4'b0001, 4'b0000, "starve");
    repeat (42) cycle(4'b1001, 4'b0000, "starve");
    chk("starve grants", 32'(q_order.size()), 32'(3));
    if (q_order.size() == 3) begin
      chk("starve order0", 32'(q_order[0]), 32'(4'b0001));
      chk("starve order1", 32'(q_order[1]), 32'(4'b1000));
      chk("starve order2", 32'(q_order[2]), 32'(4'b0001));
    end

    // data steering within one low phase while requester 2 owns the driver
    do_reset();
    repeat (2) cycle(4'b0100, 4'b0000, "steer");
    dpat = '{4'b0100, 4'b0101, 4'b0001, 4'b0000};
    apat = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.d = dpat[i];
      #1;
      chk("steer drv_a", 32'(bus.drv_a), 32'(apat[i]));
    end
    @(negedge clk);
    repeat (2) cycle(4'b0100, 4'b0100, "steer");

    // request drops on the last allowed grant cycle
    do_reset();
    repeat (16) cycle(4'b0001, 4'b0001, "coin");
    repeat (4)  cycle(4'b0000, 4'b0001, "coin");
    chk("coin on_len",   (q_on.size() > 0) ? 32'(q_on[0]) : 32'hffff, 32'(MAXHOLD));
    chk("coin timeouts", 32'(obs_to), 32'(0));

    // randomized held-request segments
    do_reset();
    for (int s = 0; s < 40; s++) begin
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) cycle(r, 4'($urandom_range(0, 15)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/drv_share_arb.md
# drv_share_arb

Round-robin arbiter and sequencer that shares one inv4x output driver among N requesters in the static cell library. It grants the driver to one requester at a time and steers that requester's data bit onto the driver input. It enforces a break-before-make dead time between owners and a maximum hold time per grant. It sits between the requesting logic and the single inv4x instance: its drv_a output feeds the inverter input a, and drv_en gates the driver.

## Interface
- N, default 4: number of requesters, 2..16.
- DEAD, default 2: dead-time cycles between owners, at least 1.
- MAXHOLD, default 16: maximum cycles in one grant, at least 1.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  level request per requester; 1 = wants the driver.
- d  input  N  data bit per requester.
- gnt  output  N  one-hot grant, registered; all zero when no owner.
- sel  output  clog2(N)  index of current or last owner, registered.
- drv_en  output  1  driver enable, registered; equals |gnt.
- drv_a  output  1  combinational, drv_en & d[sel]; drives the inverter input.
- timeout  output  1  registered one-cycle pulse when a grant is force-released at MAXHOLD.

## Operation
- Reset (async, immediate): state IDLE, gnt=0, sel=0, drv_en=0, timeout=0, round-robin pointer ptr=0, hold and dead counters 0. drv_a is therefore 0.
- States: IDLE, GRANT, DEAD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the winner w, the first index i with req[i]=1 searching ptr, ptr+1, ... modulo N.
  - At the edge: gnt=1<<w, sel=w, drv_en=1, hold counter=1, go to GRANT.
- GRANT:
  - Release when req[sel]==0 or the hold counter == MAXHOLD, evaluated at each edge.
  - On release: gnt=0, drv_en=0, ptr=(sel+1) mod N, dead counter=1, go to DEAD. sel keeps its value.
  - timeout=1 for the cycle following the edge only when the release cause is the hold limit and req[sel] is still 1.
  - Otherwise increment the hold counter and stay in GRANT.
- DEAD:
  - gnt stays 0 and requests are ignored.
  - When the dead counter == DEAD, go to IDLE at the edge; otherwise increment the counter.
- A force-released requester still holding req re-arbitrates normally. Because ptr has advanced, any other pending requester wins first.
- Requests that drop before being granted are simply not seen. There is no queuing.
- Width rules:
  - Hold counter width is clog2(MAXHOLD+1).
  - Dead counter width is clog2(DEAD+1).
  - ptr wraps from N-1 to 0.
- Invariants: gnt is never more than one-hot, and gnt is never nonzero in IDLE or DEAD.

## Timing
- Grant latency: req sampled high in IDLE at edge k means gnt, drv_en and sel are valid after edge k, with no earlier combinational path.
- Grant length: a grant lasts min(number of cycles req stays high, MAXHOLD) cycles. A req falling before edge k+m gives exactly m cycles of drv_en.
- Dead gap: drv_en is low for exactly DEAD cycles in DEAD plus 1 cycle in IDLE. The minimum gap between consecutive grants is DEAD+1 cycles.
- Single requester: a lone requester holding req continuously gets MAXHOLD on, DEAD+1 off, repeating, with a timeout pulse at each forced release.
- Request dropping at the limit: if req[sel] drops on the same edge the hold counter reaches MAXHOLD, the release counts as voluntary and timeout stays 0.
- drv_a path: drv_a follows d[sel] combinationally while drv_en=1 and is 0 otherwise.
- Reset mid-GRANT: gnt, drv_en and drv_a drop asynchronously without waiting for a clock. After reset deasserts, the first arbitration starts from ptr=0.

## Test plan
- Reset: assert rst mid-GRANT with sel=2 -> gnt=0, drv_en=0, drv_a=0 immediately. After release with req=4'b0100, gnt=4'b0100 one edge later.
- Round robin, N=4, DEAD=2: req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001. Each grant is MAXHOLD=16 cycles with a timeout pulse, and there are 3 idle cycles between grants.
- Voluntary release: req[1] high for 5 cycles -> gnt=0010 for exactly 5 cycles, timeout=0, then drv_en low for 3 cycles.
- Starvation guard: req[0] held constantly, req[3] raised during grant 0 -> after the forced release and dead time, gnt=1000 is granted before 0001 again.
- Data steering: grant to requester 2 while toggling d=4'b0100/4'b0000 -> drv_a toggles 1/0 in the same cycle. Toggling d[0] during that grant leaves drv_a unchanged.
- Edge coincidence: req[sel] drops on the 16th grant cycle -> release with timeout=0. Check that gnt is never more than one-hot in all scenarios.
